fifo_burst_reader: RTL

- Consumer-side engine for the team's fifo core: drives the read strobe and absorbs the one-cycle read latency of its registered dataout.
- Presents words on a valid/ready stream in bursts of BURSTLEN, with m_last on each burst's final word.
- Sits between a fifo instance and a downstream packetiser or DMA master.
- A top-level wrapper binds its fifo_* ports to the reader side of a fifoConnect link.

---
 rtl/fifo_burst_reader_if.sv | 40 ++++
 rtl/fifo_burst_reader.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader_if.sv
// Reader-side link between a fifo instance and the burst reader, plus the
// downstream valid/ready stream. The reader uses the master modport; the
// fifo/stream environment uses the slave modport.
interface fifo_burst_reader_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned FILLBITS = 6
);

  // Fifo side
  logic [WIDTH-1:0]    fifo_dataout;
  logic [FILLBITS-1:0] fifo_fill_level;
  logic                fifo_read;

  // Stream side
  logic [WIDTH-1:0]    m_data;
  logic                m_valid;
  logic                m_ready;
  logic                m_last;

  modport master (
    input  fifo_dataout,
    input  fifo_fill_level,
    output fifo_read,
    output m_data,
    output m_valid,
    input  m_ready,
    output m_last
  );

  modport slave (
    output fifo_dataout,
    output fifo_fill_level,
    input  fifo_read,
    input  m_data,
    input  m_valid,
    output m_ready,
    input  m_last
  );

endinterface

// File: rtl/fifo_burst_reader.sv
// Burst reader for the fifo core: issues registered read strobes, absorbs the
// fifo's registered-dataout latency in a 3-entry {data, last} buffer and
// presents words on a valid/ready stream in bursts of BURSTLEN (or a shorter
// flush burst), tagging the final word of each burst with m_last.
module fifo_burst_reader #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned BURSTLEN = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                flush,
  output logic                busy,
  fifo_burst_reader_if.master bus_io
);

  localparam int unsigned FILLBITS = $clog2(DEPTH + 1);
  localparam logic [FILLBITS-1:0] BurstLenFill = FILLBITS'(BURSTLEN);
  localparam logic [FILLBITS-1:0] FillOne      = FILLBITS'(1);

  typedef enum logic [1:0] {
    StIdle,
    StBurst,
    StDrain
  } state_e;

  state_e              state_q, state_d;
  logic [FILLBITS-1:0] remaining_q, remaining_d;
  logic                fifo_read_q, fifo_read_d;
  // last tag travelling alongside the strobe, then alongside the in-flight word
  logic                read_last_q, read_last_d;
  logic [1:0]          inflight_q, inflight_d;
  logic                inflight_last_q, inflight_last_d;

  // Output buffer: circular, 3 entries, head at rd_ptr
  logic [WIDTH-1:0]    buf_data_q [3];
  logic [WIDTH-1:0]    buf_data_d [3];
  logic                buf_last_q [3];
  logic                buf_last_d [3];
  logic [1:0]          wr_ptr_q, wr_ptr_d;
  logic [1:0]          rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;

  logic [FILLBITS-1:0] fill;
  logic                capture;
  logic                transfer;
  logic [2:0]          outstanding;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign fill        = bus_io.fifo_fill_level;
  assign capture     = (inflight_q != 2'd0);
  assign transfer    = (count_q != 2'd0) && bus_io.m_ready;
  // Every word already committed to the buffer: stored, on dataout, or strobed
  assign outstanding = 3'(count_q) + 3'(inflight_q) + 3'(fifo_read_q);

  assign bus_io.fifo_read = fifo_read_q;
  assign bus_io.m_data    = buf_data_q[rd_ptr_q];
  assign bus_io.m_last    = buf_last_q[rd_ptr_q];
  assign bus_io.m_valid   = (count_q != 2'd0);
  assign busy             = (state_q != StIdle);

  // Buffer next state: capture the word read two edges ago, pop on transfer
  always_comb begin
    buf_data_d      = buf_data_q;
    buf_last_d      = buf_last_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    inflight_d      = {1'b0, fifo_read_q};
    inflight_last_d = read_last_q;
    if (capture) begin
      buf_data_d[wr_ptr_q] = bus_io.fifo_dataout;
      buf_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d             = next_ptr(wr_ptr_q);
    end
    if (transfer) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    count_d = count_q + {1'b0, capture} - {1'b0, transfer};
  end

  // Burst control: start decision, read issue (never depends on m_ready), drain
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    fifo_read_d = 1'b0;
    read_last_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && (fill >= BurstLenFill)) begin
          remaining_d = BurstLenFill;
          state_d     = StBurst;
        end else if (enable && flush && (fill != '0)) begin
          remaining_d = fill;
          state_d     = StBurst;
        end
      end
      StBurst: begin
        if ((remaining_q != '0) && (fill != '0) && (outstanding < 3'd3)) begin
          fifo_read_d = 1'b1;
          read_last_d = (remaining_q == FillOne);
          remaining_d = remaining_q - FillOne;
          if (remaining_q == FillOne) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Leave as the last-tagged word transfers so IDLE lasts exactly one cycle
        if ((count_d == 2'd0) && !fifo_read_q && (inflight_q == 2'd0)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // All state; reset discards any partially delivered burst
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      remaining_q     <= '0;
      fifo_read_q     <= 1'b0;
      read_last_q     <= 1'b0;
      inflight_q      <= 2'd0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= 2'd0;
      rd_ptr_q        <= 2'd0;
      count_q         <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
    end else begin
      state_q         <= state_d;
      remaining_q     <= remaining_d;
      fifo_read_q     <= fifo_read_d;
      read_last_q     <= read_last_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      buf_data_q      <= buf_data_d;
      buf_last_q      <= buf_last_d;
    end
  end

endmodule
